// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and sizing helpers for the shared-register round-robin arbiter.
// Imported by the interface, the picker and the top.
package shared_reg_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  localparam int DEFAULT_N       = 4;
  localparam int DEFAULT_W       = 8;
  localparam int DEFAULT_MAXLOCK = 16;

  // Ceiling log2, never below 1 so that every index/counter has at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of the shared-register arbiter: requests, data, grants,
// acknowledges and the shared register view.
interface shared_reg_arbiter_if
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int W = DEFAULT_W
);
  localparam int IW = clog2(N);

  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic [IW-1:0]  owner;
  logic           busy;

  modport master (
    output req, lock, wdata,
    input  gnt, ack, q, owner, busy
  );

  modport slave (
    input  req, lock, wdata,
    output gnt, ack, q, owner, busy
  );

endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N (N need not be a power of two).
module shared_reg_arbiter_rr_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   idx_sum;

  // rot[i] is the request of requester (ptr + i) mod N, so bit 0 has top priority.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      logic [IW:0]   sum;
      logic [IW-1:0] wrapped;
      assign sum     = {1'b0, ptr} + (IW+1)'(gi);
      assign wrapped = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
      assign rot[gi] = req[wrapped];
    end
  endgenerate

  always_comb begin
    valid = 1'b0;
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid = 1'b1;
        off   = IW'(i);
      end
    end
  end

  assign idx_sum = {1'b0, ptr} + {1'b0, off};
  assign idx     = (idx_sum >= (IW+1)'(N)) ? IW'(idx_sum - (IW+1)'(N)) : IW'(idx_sum);

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one W-bit register among N requesters, with an
// optional lock that allows up to MAXLOCK back-to-back writes per ownership.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N       = DEFAULT_N,
  parameter int W       = DEFAULT_W,
  parameter int MAXLOCK = DEFAULT_MAXLOCK
) (
  input logic                 clk,
  input logic                 clr,
  shared_reg_arbiter_if.slave bus
);

  localparam int IW = clog2(N);
  localparam int CW = clog2(MAXLOCK + 1);

  arb_state_t    state_reg, state_next;
  logic [IW-1:0] ptr_reg, ptr_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [N-1:0]  gnt_reg, gnt_next;
  logic [N-1:0]  ack_reg, ack_next;
  logic [W-1:0]  q_reg, q_next;
  logic [IW-1:0] owner_reg, owner_next;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [CW-1:0] cnt_inc;
  logic          release_own;
  logic [W-1:0]  wdata_arr [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      assign wdata_arr[gi] = bus.wdata[gi*W +: W];
    end
  endgenerate

  shared_reg_arbiter_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      gnt_reg   <= '0;
      ack_reg   <= '0;
      q_reg     <= '0;
      owner_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      gnt_reg   <= gnt_next;
      ack_reg   <= ack_next;
      q_reg     <= q_next;
      owner_reg <= owner_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    cnt_next    = cnt_reg;
    gnt_next    = gnt_reg;
    ack_next    = '0;
    q_next      = q_reg;
    owner_next  = owner_reg;
    release_own = 1'b0;
    cnt_inc     = cnt_reg + 1'b1;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          gnt_next   = N'(1) << pick_idx;
          owner_next = pick_idx;
          cnt_next   = '0;
          state_next = OWN;
        end
      end
      OWN: begin
        // Only the owner's request/lock/data matter while it holds the grant.
        if (bus.req[owner_reg]) begin
          q_next      = wdata_arr[owner_reg];
          ack_next    = N'(1) << owner_reg;
          cnt_next    = cnt_inc;
          release_own = !(bus.lock[owner_reg] && (cnt_inc < CW'(MAXLOCK)));
        end else begin
          release_own = 1'b1;
        end
        if (release_own) begin
          state_next = IDLE;
          gnt_next   = '0;
          ptr_next   = (owner_reg == IW'(N - 1)) ? '0 : owner_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.gnt   = gnt_reg;
  assign bus.ack   = ack_reg;
  assign bus.q     = q_reg;
  assign bus.owner = owner_reg;
  assign bus.busy  = (state_reg == OWN);

endmodule
